valu_operand_collector: RTL
===========================

# valu_operand_collector

Upstream feeder for the 16-lane vector ALU. Accepts one issued vector instruction at a time, fetches up to three 512-bit source operands over a single VGPR read port, and presents them to the ALU with control, VCC and EXEC. It then pulses the ALU start strobe, holds all ALU inputs stable until the ALU reports done, and signals completion to the issue stage.

## Interface
Parameters:
- ADDR_W, 9, VGPR read address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- issue_valid  input  1  instruction offered.
- issue_ready  output  1  collector can accept; high only in IDLE.
- issue_control  input  32  ALU opcode/control word.
- issue_src_count  input  2  number of operands to fetch, 0..3.
- issue_src_addr  input  3*ADDR_W  operand addresses; src1 in [ADDR_W-1:0], src2 next, src3 top.
- issue_vcc  input  16  per-lane VCC.
- issue_exec  input  16  per-lane EXEC mask.
- vgpr_rd_en  output  1  single-cycle read request.
- vgpr_rd_addr  output  ADDR_W  read address, valid with vgpr_rd_en.
- vgpr_rd_data  input  512  returned operand.
- vgpr_rd_valid  input  1  vgpr_rd_data valid; arbitrary latency of 1 or more cycles.
- alu_source1_data, alu_source2_data, alu_source3_data  output  512 each  operands to the ALU.
- alu_source_vcc_value  output  16  latched VCC.
- alu_source_exec_value  output  16  latched EXEC.
- alu_control  output  32  latched control word; 0 when no instruction is in flight.
- alu_start  output  1  one-cycle start strobe.
- valu_done  input  1  ALU completion.
- collector_done  output  1  one-cycle completion pulse to the issue stage.

## Operation
- States: IDLE, FETCH, WAIT, START, EXEC.
- IDLE
  - issue_ready=1.
  - On issue_valid: latch control, addresses, count, VCC and EXEC.
  - Zero all three operand registers.
  - Reset the operand index to 0.
  - Next state:
    - control==0: stay IDLE and pulse collector_done on the following cycle (NOP; the ALU is never started).
    - count==0: go to START.
    - otherwise: go to FETCH.
- FETCH
  - Drive vgpr_rd_en=1 for exactly one cycle, with the address of operand[index].
  - Next state: WAIT.
- WAIT
  - At most one outstanding read.
  - On vgpr_rd_valid: write vgpr_rd_data into operand[index] and increment index.
  - If index+1 < count, go to FETCH; else go to START.
- START
  - alu_start=1 for one cycle. All alu_* outputs are already stable.
  - Next state: EXEC.
- EXEC
  - Hold every alu_* output.
  - On valu_done: collector_done=1 (combinational, this cycle); clear alu_control to 0; next state IDLE.
- Operands at positions >= count stay 0.
- EXEC==0 is legal; the ALU reports done immediately and is treated normally.
- vgpr_rd_valid outside WAIT is ignored. valu_done outside EXEC is ignored.

## Timing
- Reset values: every output is 0 except issue_ready=1. State is IDLE.
- Reset asserted mid-operation returns to IDLE immediately. A read returning after reset is ignored.
- Latency, issue accepted at cycle T, read latency L:
  - first vgpr_rd_en at T+1;
  - each further operand adds L+1 cycles;
  - alu_start at T+1+count*(L+1);
  - count==0: alu_start at T+1.
- collector_done coincides with the cycle in which valu_done is sampled in EXEC.
- issue_ready returns high on the next cycle after collector_done.
- Throughput is one instruction per (operand fetch + ALU) period. No overlap between instructions.
- All outputs except collector_done are registered.

## Test plan
- Three operands, L=1, addr 5/6/7, control 0x1, EXEC 0xFFFF, VCC 0x00F0:
  - rd_en at T+1, T+3, T+5 with addresses 5, 6, 7;
  - alu_start at T+7 with all three operands matching the returned data;
  - VCC 0x00F0 and control 0x1 held until valu_done.
- One operand, L=4:
  - single read;
  - source2 and source3 equal 0;
  - alu_start at T+6.
- count=0, control 0x3:
  - no rd_en;
  - alu_start at T+1;
  - collector_done when valu_done is asserted.
- control=0:
  - no rd_en and no alu_start;
  - collector_done at T+1;
  - issue_ready stays high.
- Spurious inputs:
  - vgpr_rd_valid pulsed in IDLE and valu_done pulsed in START are ignored;
  - spurious rd_valid leaves operands 0;
  - no early completion.
- rst low while in WAIT:
  - all outputs return to their reset values;
  - a late vgpr_rd_valid does not alter the operands;
  - the next issue proceeds normally.

Source files
------------

// File: rtl/valu_operand_collector_if.sv
// rtl/valu_operand_collector_if.sv - issue, VGPR read and ALU bus bundle for the VALU operand collector
//
// Purpose: groups every non-clock, non-reset signal of the operand collector.
// Modports:
//   slave  - the collector: consumes issue/VGPR-return/ALU-done, drives the rest
//   master - the environment (issue stage, VGPR file, ALU) facing the collector
interface valu_operand_collector_if #(
    parameter int ADDR_W = 9
);
    // issue stage
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_control;
    logic [1:0]            issue_src_count;
    logic [3*ADDR_W-1:0]   issue_src_addr;
    logic [15:0]           issue_vcc;
    logic [15:0]           issue_exec;
    // VGPR read port
    logic                  vgpr_rd_en;
    logic [ADDR_W-1:0]     vgpr_rd_addr;
    logic [511:0]          vgpr_rd_data;
    logic                  vgpr_rd_valid;
    // ALU
    logic [511:0]          alu_source1_data;
    logic [511:0]          alu_source2_data;
    logic [511:0]          alu_source3_data;
    logic [15:0]           alu_source_vcc_value;
    logic [15:0]           alu_source_exec_value;
    logic [31:0]           alu_control;
    logic                  alu_start;
    logic                  valu_done;
    logic                  collector_done;

    modport slave (
        input  issue_valid, issue_control, issue_src_count, issue_src_addr,
               issue_vcc, issue_exec, vgpr_rd_data, vgpr_rd_valid, valu_done,
        output issue_ready, vgpr_rd_en, vgpr_rd_addr,
               alu_source1_data, alu_source2_data, alu_source3_data,
               alu_source_vcc_value, alu_source_exec_value, alu_control,
               alu_start, collector_done
    );

    modport master (
        output issue_valid, issue_control, issue_src_count, issue_src_addr,
               issue_vcc, issue_exec, vgpr_rd_data, vgpr_rd_valid, valu_done,
        input  issue_ready, vgpr_rd_en, vgpr_rd_addr,
               alu_source1_data, alu_source2_data, alu_source3_data,
               alu_source_vcc_value, alu_source_exec_value, alu_control,
               alu_start, collector_done
    );
endinterface

// File: rtl/valu_operand_collector.sv
// rtl/valu_operand_collector.sv - fetches up to three VGPR operands and sequences one VALU operation
//
// Purpose: accepts one issued vector instruction, reads its source operands one
// at a time over a single VGPR read port, presents operands/control/VCC/EXEC to
// the ALU, strobes alu_start, holds everything until valu_done and then pulses
// collector_done back to the issue stage.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - valu_operand_collector_if.slave (issue, VGPR read, ALU signals)
// All outputs are registered except collector_done.
module valu_operand_collector #(
    parameter int ADDR_W = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    valu_operand_collector_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_START,
        S_EXEC
    } state_t;

    state_t                state;
    logic [3*ADDR_W-1:0]   addr_q;
    logic [1:0]            count_q;
    logic [1:0]            idx_q;
    logic                  nop_done_q;
    logic                  issue_ready_q;
    logic                  rd_en_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [511:0]          src1_q;
    logic [511:0]          src2_q;
    logic [511:0]          src3_q;
    logic [15:0]           vcc_q;
    logic [15:0]           exec_q;
    logic [31:0]           control_q;
    logic                  start_q;

    // Index of the operand after the one currently being returned; one bit
    // wider than idx_q so the compare against count cannot wrap.
    logic [2:0]            idx_next;
    logic [ADDR_W-1:0]     next_addr;

    assign idx_next = {1'b0, idx_q} + 3'd1;

    always_comb begin
        next_addr = addr_q[ADDR_W-1:0];
        case (idx_next[1:0])
            2'd1:    next_addr = addr_q[2*ADDR_W-1:ADDR_W];
            2'd2:    next_addr = addr_q[3*ADDR_W-1:2*ADDR_W];
            default: next_addr = addr_q[ADDR_W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            nop_done_q    <= 1'b0;
            issue_ready_q <= 1'b1;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            src3_q        <= '0;
            vcc_q         <= '0;
            exec_q        <= '0;
            control_q     <= '0;
            start_q       <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            nop_done_q <= 1'b0;
            rd_en_q    <= 1'b0;
            start_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.issue_valid) begin
                        addr_q    <= bus.issue_src_addr;
                        count_q   <= bus.issue_src_count;
                        vcc_q     <= bus.issue_vcc;
                        exec_q    <= bus.issue_exec;
                        control_q <= bus.issue_control;
                        src1_q    <= '0;
                        src2_q    <= '0;
                        src3_q    <= '0;
                        idx_q     <= '0;
                        if (bus.issue_control == 32'd0) begin
                            // NOP: complete without touching the ALU.
                            nop_done_q <= 1'b1;
                        end else if (bus.issue_src_count == 2'd0) begin
                            issue_ready_q <= 1'b0;
                            start_q       <= 1'b1;
                            state         <= S_START;
                        end else begin
                            issue_ready_q <= 1'b0;
                            rd_en_q       <= 1'b1;
                            rd_addr_q     <= bus.issue_src_addr[ADDR_W-1:0];
                            state         <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.vgpr_rd_valid) begin
                        case (idx_q)
                            2'd0:    src1_q <= bus.vgpr_rd_data;
                            2'd1:    src2_q <= bus.vgpr_rd_data;
                            default: src3_q <= bus.vgpr_rd_data;
                        endcase
                        idx_q <= idx_next[1:0];
                        if (idx_next < {1'b0, count_q}) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= next_addr;
                            state     <= S_FETCH;
                        end else begin
                            start_q <= 1'b1;
                            state   <= S_START;
                        end
                    end
                end
                S_START: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (bus.valu_done) begin
                        control_q     <= '0;
                        issue_ready_q <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.issue_ready           = issue_ready_q;
    assign bus.vgpr_rd_en            = rd_en_q;
    assign bus.vgpr_rd_addr          = rd_addr_q;
    assign bus.alu_source1_data      = src1_q;
    assign bus.alu_source2_data      = src2_q;
    assign bus.alu_source3_data      = src3_q;
    assign bus.alu_source_vcc_value  = vcc_q;
    assign bus.alu_source_exec_value = exec_q;
    assign bus.alu_control           = control_q;
    assign bus.alu_start             = start_q;
    // Completion is combinational on valu_done so the issue stage sees it in
    // the same cycle the ALU finishes.
    assign bus.collector_done        = nop_done_q | ((state == S_EXEC) & bus.valu_done);

endmodule
